hbm_axi_traffic_chk: RTL and testbench

- Synthesizable AXI4 traffic generator/checker that runs write-burst / read-back / compare sequences across NUM_CHANNELS HBM pseudo-channel address windows.
- It is the RTL successor to the BFM-driven bring-up sequence. It sits on an intel_noc_initiator AXI4 port in place of an mgc_axi4_master instance and runs on hardware as well as in simulation.
- Adds run-time burst length, iteration count, pattern selection and per-channel data scaling, and reports error counts and the first failing address.

---
 rtl/hbm_axi_traffic_chk.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_hbm_axi_traffic_chk.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_axi_traffic_chk.sv
// AXI4 write-burst / read-back / compare traffic checker that sweeps NUM_CHANNELS
// HBM pseudo-channel windows, one outstanding transaction at a time.
module hbm_axi_traffic_chk #(
    parameter int          DATA_WIDTH   = 256,
    parameter int          ADDR_WIDTH   = 64,
    parameter int          ID_WIDTH     = 7,
    parameter int          NUM_CHANNELS = 2,
    parameter logic [63:0] BASE_ADDR    = 64'h0,
    parameter logic [63:0] CH_STRIDE    = 64'h4000_0000
) (
    input  logic                      clk100_in_clk,
    input  logic                      axi_reset_n_in_reset_n,
    input  logic                      start,
    input  logic [2:0]                burst_log2,
    input  logic [15:0]               num_iter,
    input  logic                      pattern_sel,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               err_count,
    output logic [ADDR_WIDTH-1:0]     first_err_addr,
    output logic [ID_WIDTH-1:0]       awid,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [ID_WIDTH-1:0]       bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [ID_WIDTH-1:0]       arid,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [ID_WIDTH-1:0]       rid,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LOG_BYTES = $clog2(BYTES);
    localparam int MAXLOG    = ((12 - LOG_BYTES) < 7) ? (12 - LOG_BYTES) : 7;
    localparam logic [3:0] LAST_CH = 4'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_NEXT = 3'd6,
        S_DONE = 3'd7
    } state_t;

    // v = (n*L + k) * (c + 1); the product fits 37 bits, so truncation/extension is exact.
    function automatic logic [DATA_WIDTH-1:0] pattern_fn(input logic [15:0] n,
                                                         input logic [7:0]  k,
                                                         input logic [2:0]  eff,
                                                         input logic [3:0]  c,
                                                         input logic        inv);
        logic [31:0]           idx;
        logic [36:0]           prod;
        logic [DATA_WIDTH-1:0] v;
        idx  = ({16'd0, n} << eff) + {24'd0, k};
        prod = {5'd0, idx} * {32'd0, ({1'b0, c} + 5'd1)};
        v    = DATA_WIDTH'(prod);
        return inv ? ~v : v;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_fn(input logic [15:0] n,
                                                      input logic [3:0]  c,
                                                      input logic [2:0]  eff);
        logic [ADDR_WIDTH-1:0] chan_off;
        logic [ADDR_WIDTH-1:0] iter_off;
        chan_off = ADDR_WIDTH'(CH_STRIDE) * ADDR_WIDTH'(c);
        iter_off = ADDR_WIDTH'(n) << ({2'b00, eff} + 5'(LOG_BYTES));
        return ADDR_WIDTH'(BASE_ADDR) + chan_off + iter_off;
    endfunction

    state_t                state_q, state_d;
    logic [3:0]            c_q, c_d;
    logic [15:0]           n_q, n_d;
    logic [7:0]            beat_q, beat_d;
    logic [2:0]            eff_q;
    logic [7:0]            len_q;
    logic [15:0]           last_iter_q;
    logic                  pat_q;
    logic [ADDR_WIDTH-1:0] burst_addr_q;
    logic [15:0]           err_count_q;
    logic [ADDR_WIDTH-1:0] first_err_q;
    logic                  awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
    logic                  busy_q, done_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [2:0]            eff_s;
    logic                  start_ok_s;
    logic [DATA_WIDTH-1:0] exp_data_s;
    logic                  err_hit_s;
    logic [ADDR_WIDTH-1:0] err_addr_s;

    assign eff_s      = (burst_log2 > 3'(MAXLOG)) ? 3'(MAXLOG) : burst_log2;
    assign start_ok_s = (state_q == S_IDLE) && start;
    assign exp_data_s = pattern_fn(n_q, beat_q, eff_q, c_q, pat_q);

    // Next-state, beat/channel/iteration sequencing and per-beat error detection.
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        n_d        = n_q;
        beat_d     = beat_q;
        err_hit_s  = 1'b0;
        err_addr_s = burst_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_AW;
                    c_d     = 4'd0;
                    n_d     = 16'd0;
                    beat_d  = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                if (awready) begin
                    state_d = S_W;
                    beat_d  = 8'd0;
                end else begin
                    state_d = S_AW;
                end
            end
            S_W: begin
                if (wready) begin
                    if (beat_q == len_q) begin
                        state_d = S_B;
                        beat_d  = 8'd0;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end else begin
                    state_d = S_W;
                end
            end
            S_B: begin
                if (bvalid) begin
                    err_hit_s = (bresp != 2'b00) || (bid != ID_WIDTH'(c_q));
                    state_d   = S_AR;
                end else begin
                    state_d = S_B;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                    beat_d  = 8'd0;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (rvalid) begin
                    // Any combination of faults on one beat counts as a single error.
                    err_hit_s  = (rdata != exp_data_s) || (rresp != 2'b00) ||
                                 (rid != ID_WIDTH'(c_q)) || (rlast != (beat_q == len_q));
                    err_addr_s = burst_addr_q + (ADDR_WIDTH'(beat_q) << LOG_BYTES);
                    if (beat_q == len_q) begin
                        state_d = S_NEXT;
                        beat_d  = 8'd0;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end else begin
                    state_d = S_R;
                end
            end
            S_NEXT: begin
                if (c_q == LAST_CH) begin
                    c_d = 4'd0;
                    if (n_q == last_iter_q) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + 16'd1;
                        state_d = S_AW;
                    end
                end else begin
                    c_d     = c_q + 4'd1;
                    state_d = S_AW;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and loop counters.
    always_ff @(posedge clk100_in_clk or negedge axi_reset_n_in_reset_n) begin
        if (!axi_reset_n_in_reset_n) begin
            state_q <= S_IDLE;
            c_q     <= 4'd0;
            n_q     <= 16'd0;
            beat_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            n_q     <= n_d;
            beat_q  <= beat_d;
        end
    end

    // Run configuration captured at start; burst base recomputed on each channel step.
    always_ff @(posedge clk100_in_clk or negedge axi_reset_n_in_reset_n) begin
        if (!axi_reset_n_in_reset_n) begin
            eff_q        <= 3'd0;
            len_q        <= 8'd0;
            last_iter_q  <= 16'd0;
            pat_q        <= 1'b0;
            burst_addr_q <= '0;
        end else if (start_ok_s) begin
            eff_q        <= eff_s;
            len_q        <= 8'((9'd1 << eff_s) - 9'd1);
            last_iter_q  <= (num_iter == 16'd0) ? 16'd0 : (num_iter - 16'd1);
            pat_q        <= pattern_sel;
            burst_addr_q <= ADDR_WIDTH'(BASE_ADDR);
        end else if (state_q == S_NEXT) begin
            burst_addr_q <= addr_fn(n_d, c_d, eff_q);
        end
    end

    // Saturating error counter; the first failing address is only captured from zero.
    always_ff @(posedge clk100_in_clk or negedge axi_reset_n_in_reset_n) begin
        if (!axi_reset_n_in_reset_n) begin
            err_count_q <= 16'd0;
            first_err_q <= '0;
        end else if (start_ok_s) begin
            err_count_q <= 16'd0;
            first_err_q <= '0;
        end else if (err_hit_s) begin
            if (err_count_q == 16'd0) begin
                first_err_q <= err_addr_s;
            end
            if (err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    // Handshake and status outputs decoded from the next state so they leave flops.
    always_ff @(posedge clk100_in_clk or negedge axi_reset_n_in_reset_n) begin
        if (!axi_reset_n_in_reset_n) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            wdata_q   <= '0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            awvalid_q <= (state_d == S_AW);
            wvalid_q  <= (state_d == S_W);
            wlast_q   <= (state_d == S_W) && (beat_d == len_q);
            wdata_q   <= pattern_fn(n_q, beat_d, eff_q, c_q, pat_q);
            bready_q  <= (state_d == S_B);
            arvalid_q <= (state_d == S_AR);
            rready_q  <= (state_d == S_R);
            busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;

    assign awid    = ID_WIDTH'(c_q);
    assign awaddr  = burst_addr_q;
    assign awlen   = len_q;
    assign awsize  = 3'(LOG_BYTES);
    assign awburst = 2'b01;
    assign awvalid = awvalid_q;

    assign wdata  = wdata_q;
    assign wstrb  = {(DATA_WIDTH/8){1'b1}};
    assign wlast  = wlast_q;
    assign wvalid = wvalid_q;
    assign bready = bready_q;

    assign arid    = ID_WIDTH'(c_q);
    assign araddr  = burst_addr_q;
    assign arlen   = len_q;
    assign arsize  = 3'(LOG_BYTES);
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

endmodule

// File: tb/tb_hbm_axi_traffic_chk.sv
// Scoreboarded bench for hbm_axi_traffic_chk: an AXI slave memory model checks every
// address/data beat against queued expectations; directed runs check status outputs.
module tb_hbm_axi_traffic_chk;

    localparam int DW = 256;
    localparam int AW = 64;
    localparam int IW = 7;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [2:0]      burst_log2;
    logic [15:0]     num_iter;
    logic            pattern_sel;
    logic            busy, done;
    logic [15:0]     err_count;
    logic [AW-1:0]   first_err_addr;
    logic [IW-1:0]   awid, arid, bid, rid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;

    hbm_axi_traffic_chk dut (
        .clk100_in_clk(clk), .axi_reset_n_in_reset_n(rst_n), .start(start),
        .burst_log2(burst_log2), .num_iter(num_iter), .pattern_sel(pattern_sel),
        .busy(busy), .done(done), .err_count(err_count), .first_err_addr(first_err_addr),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [6:0]  id;
    } ax_t;

    typedef struct packed {
        logic [255:0] data;
        logic         last;
    } wb_t;

    ax_t          exp_aw[$];
    ax_t          exp_ar[$];
    wb_t          exp_w[$];
    logic [255:0] mem [logic [63:0]];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit stall_mode = 1'b0;
    bit corrupt_mode = 1'b0;
    bit slverr_mode = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count done pulses on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // Slave memory model: handshakes that completed at the last rising edge are retired
    // first, then new ready/valid values are driven for the next rising edge.
    bit          p_aw, p_w, p_b, p_ar, p_r, aw_hold, w_hold, ar_hold, aw_open, b_pend, r_act;
    ax_t         cap_aw, cap_ar;
    logic [2:0]  cap_awsize, cap_arsize;
    logic [1:0]  cap_awburst, cap_arburst;
    logic [31:0] cap_wstrb;
    wb_t         cap_w;
    logic [63:0] cur_addr, r_addr;
    logic [6:0]  cur_id, r_id_s;
    logic [7:0]  r_len;
    int          wbeat, rbeat;

    always @(negedge clk) begin
        ax_t         e;
        wb_t         ew;
        logic [63:0] a;
        if (!rst_n) begin
            {p_aw, p_w, p_b, p_ar, p_r, aw_hold, w_hold, ar_hold} = 8'd0;
            {aw_open, b_pend, r_act} = 3'd0;
            wbeat = 0;
            rbeat = 0;
            awready = 1'b0; wready = 1'b0; arready = 1'b0;
            bvalid = 1'b0; bid = 7'd0; bresp = 2'b00;
            rvalid = 1'b0; rid = 7'd0; rdata = 256'd0; rresp = 2'b00; rlast = 1'b0;
            exp_aw.delete();
            exp_ar.delete();
            exp_w.delete();
        end else begin
            if (aw_hold) chk("aw_stable", {awvalid, awaddr, awlen, awid}, {1'b1, cap_aw});
            if (w_hold)  chk("w_stable", {wvalid, wdata, wlast}, {1'b1, cap_w});
            if (ar_hold) chk("ar_stable", {arvalid, araddr, arlen, arid}, {1'b1, cap_ar});
            if (p_aw) begin
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_aw.pop_front();
                    chk("awaddr", cap_aw.addr, e.addr);
                    chk("awlen", cap_aw.len, e.len);
                    chk("awid", cap_aw.id, e.id);
                end
                chk("awsize", cap_awsize, 3'd5);
                chk("awburst", cap_awburst, 2'b01);
                aw_open  = 1'b1;
                wbeat    = 0;
                cur_addr = cap_aw.addr;
                cur_id   = cap_aw.id;
            end
            if (p_w) begin
                if (exp_w.size() == 0) begin
                    chk("w_unexpected", 1'b1, 1'b0);
                end else begin
                    ew = exp_w.pop_front();
                    chk("wdata", cap_w.data, ew.data);
                    chk("wlast", cap_w.last, ew.last);
                end
                chk("wstrb", cap_wstrb, 32'hFFFF_FFFF);
                mem[cur_addr + 64'(wbeat * 32)] = cap_w.data;
                wbeat++;
                if (cap_w.last) begin
                    aw_open = 1'b0;
                    b_pend  = 1'b1;
                end
            end
            if (p_b) begin
                bvalid = 1'b0;
                b_pend = 1'b0;
            end
            if (p_ar) begin
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_ar.pop_front();
                    chk("araddr", cap_ar.addr, e.addr);
                    chk("arlen", cap_ar.len, e.len);
                    chk("arid", cap_ar.id, e.id);
                end
                chk("arsize", cap_arsize, 3'd5);
                chk("arburst", cap_arburst, 2'b01);
                r_act  = 1'b1;
                r_addr = cap_ar.addr;
                r_len  = cap_ar.len;
                r_id_s = cap_ar.id;
                rbeat  = 0;
            end
            if (p_r) begin
                rvalid = 1'b0;
                rbeat++;
                if (rbeat > int'(r_len)) r_act = 1'b0;
            end
            awready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            arready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_pend && !bvalid) begin
                bvalid = 1'b1;
                bid    = cur_id;
                bresp  = slverr_mode ? 2'b10 : 2'b00;
            end
            if (r_act && !rvalid && (!stall_mode || ($urandom_range(0, 1) == 1))) begin
                a     = r_addr + 64'(rbeat * 32);
                rdata = mem.exists(a) ? mem[a] : 256'd0;
                if (corrupt_mode && r_id_s == 7'd1 && r_addr == 64'h4000_0000 && rbeat == 3)
                    rdata = rdata ^ 256'd1;
                rid    = r_id_s;
                rresp  = 2'b00;
                rlast  = (rbeat == int'(r_len));
                rvalid = 1'b1;
            end
            if (wvalid) chk("wvalid_before_aw", aw_open, 1'b1);
            p_aw    = awvalid && awready;
            aw_hold = awvalid && !awready;
            p_w     = wvalid && wready;
            w_hold  = wvalid && !wready;
            p_b     = bvalid && bready;
            p_ar    = arvalid && arready;
            ar_hold = arvalid && !arready;
            p_r     = rvalid && rready;
            cap_aw      = '{addr: awaddr, len: awlen, id: awid};
            cap_awsize  = awsize;
            cap_awburst = awburst;
            cap_ar      = '{addr: araddr, len: arlen, id: arid};
            cap_arsize  = arsize;
            cap_arburst = arburst;
            cap_w       = '{data: wdata, last: wlast};
            cap_wstrb   = wstrb;
        end
    end

    // Reference model of the address/data sequence, pushed before each run starts.
    task automatic push_exp(input int bl, input int ni, input bit ps);
        int           eff, len, iters;
        logic [255:0] v;
        eff   = (bl > 7) ? 7 : bl;
        len   = 1 << eff;
        iters = (ni == 0) ? 1 : ni;
        for (int n = 0; n < iters; n++) begin
            for (int c = 0; c < 2; c++) begin
                exp_aw.push_back('{addr: 64'(c) * 64'h4000_0000 + 64'(n * len * 32),
                                   len: 8'(len - 1), id: 7'(c)});
                exp_ar.push_back('{addr: 64'(c) * 64'h4000_0000 + 64'(n * len * 32),
                                   len: 8'(len - 1), id: 7'(c)});
                for (int k = 0; k < len; k++) begin
                    v = 256'((n * len + k) * (c + 1));
                    exp_w.push_back('{data: ps ? ~v : v, last: (k == len - 1)});
                end
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_and_check(input string tag, input int base_done,
                                  input logic [15:0] e_err, input logic [63:0] e_first);
        int cyc;
        cyc = 0;
        while (!((done_cnt > base_done) && !busy) && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_timeout"}, (cyc < 20000), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, done_cnt - base_done, 1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err_count"}, err_count, e_err);
        chk({tag, "_first_err_addr"}, first_err_addr, e_first);
        chk({tag, "_w_left"}, exp_w.size(), 0);
        chk({tag, "_aw_left"}, exp_aw.size(), 0);
        chk({tag, "_ar_left"}, exp_ar.size(), 0);
    endtask

    task automatic run_seq(input string tag, input int bl, input int ni, input bit ps,
                           input logic [15:0] e_err, input logic [63:0] e_first);
        int base;
        push_exp(bl, ni, ps);
        burst_log2  = 3'(bl);
        num_iter    = 16'(ni);
        pattern_sel = ps;
        base        = done_cnt;
        pulse_start();
        wait_and_check(tag, base, e_err, e_first);
    endtask

    initial begin
        int w;
        int base;
        rst_n = 1'b0;
        start = 1'b0;
        burst_log2 = 3'd3;
        num_iter = 16'd1;
        pattern_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {busy, done, awvalid, wvalid, arvalid, bready, rready}, 7'd0);
        chk("rst_err_count", err_count, 16'd0);
        chk("rst_first_err", first_err_addr, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_seq("basic", 3, 1, 1'b0, 16'd0, 64'd0);

        stall_mode = 1'b1;
        run_seq("stall", 3, 1, 1'b0, 16'd0, 64'd0);
        stall_mode = 1'b0;

        corrupt_mode = 1'b1;
        run_seq("corrupt", 3, 1, 1'b0, 16'd1, 64'h4000_0060);
        corrupt_mode = 1'b0;

        run_seq("long_inv", 7, 3, 1'b1, 16'd0, 64'd0);

        slverr_mode = 1'b1;
        run_seq("slverr", 3, 1, 1'b0, 16'd2, 64'd0);
        slverr_mode = 1'b0;

        // Reset in the middle of a write burst, then a fresh run.
        push_exp(3, 1, 1'b0);
        burst_log2 = 3'd3;
        num_iter = 16'd1;
        pattern_sel = 1'b0;
        pulse_start();
        w = 0;
        while (!wvalid && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("midw_reached_w", wvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midw_rst_outputs", {busy, done, awvalid, wvalid, arvalid, bready, rready}, 7'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("midw_rst_hold", {busy, awvalid, wvalid, arvalid}, 4'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_seq("after_rst", 3, 1, 1'b0, 16'd0, 64'd0);

        // A second start while busy must be ignored.
        stall_mode = 1'b1;
        push_exp(3, 1, 1'b0);
        burst_log2 = 3'd3;
        num_iter = 16'd1;
        pattern_sel = 1'b0;
        base = done_cnt;
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        chk("busy_during_run", busy, 1'b1);
        burst_log2 = 3'd7;
        num_iter = 16'd4;
        pulse_start();
        wait_and_check("start_busy", base, 16'd0, 64'd0);
        stall_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
